// File: rtl/jtframe_rom_arb.sv
// Per-slot one-word ROM cache in front of the single SDRAM read port; misses are arbitrated onto sdram_req/sdram_addr.
// Optional JTFRAME_ARB_RR_EN selects round-robin arbitration instead of fixed priority (slot 0 highest).
module jtframe_rom_arb #(
    parameter int SLOTS = 4,
    parameter int AW    = 22,
    parameter int DW    = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                downloading,
    input  logic [SLOTS-1:0]    slot_req,
    input  logic [SLOTS*AW-1:0] slot_addr,
    output logic [SLOTS-1:0]    slot_ok,
    output logic [SLOTS*DW-1:0] slot_dout,
    output logic                sdram_req,
    output logic [AW-1:0]       sdram_addr,
    input  logic                sdram_ack,
    input  logic                data_rdy,
    input  logic [DW-1:0]       data_read,
    output logic                refresh_en
);

    localparam int GW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ACK = 2'd1,
        WAIT_RDY = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [SLOTS-1:0]  valid, valid_nxt;
    logic [SLOTS-1:0]  miss;
    logic [AW-1:0]     cache_addr [SLOTS];
    logic [DW-1:0]     cache_data [SLOTS];
    logic [GW-1:0]     grant, grant_nxt, win;
    logic              any_miss;
    logic              fill;
    logic              req_nxt;
    logic              refresh_nxt;
    logic [AW-1:0]     addr_nxt;

    // Hits are combinational so a cached word is returned with no added latency.
    for (genvar i = 0; i < SLOTS; i++) begin : g_slot
        assign slot_ok[i]              = slot_req[i] & valid[i] &
                                         (cache_addr[i] == slot_addr[i*AW +: AW]);
        assign miss[i]                 = slot_req[i] & ~slot_ok[i];
        assign slot_dout[i*DW +: DW]   = cache_data[i];
    end

    assign any_miss = |miss;

`ifdef JTFRAME_ARB_RR_EN
    logic [GW-1:0] rr_ptr;

    function automatic logic [GW-1:0] wrap_idx(input int v);
        return GW'(v % SLOTS);
    endfunction

    // Walk backwards so the miss closest to rr_ptr is the last one assigned.
    always_comb begin
        win = '0;
        for (int k = SLOTS - 1; k >= 0; k--) begin
            if (miss[wrap_idx(int'(rr_ptr) + k)]) win = wrap_idx(int'(rr_ptr) + k);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (state == IDLE && !downloading && any_miss) begin
            rr_ptr <= (win == GW'(SLOTS - 1)) ? '0 : win + 1'b1;
        end
    end
`else
    always_comb begin
        win = '0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (miss[i]) win = GW'(i);
        end
    end
`endif

    always_comb begin
        state_nxt   = state;
        req_nxt     = sdram_req;
        addr_nxt    = sdram_addr;
        grant_nxt   = grant;
        refresh_nxt = refresh_en;
        valid_nxt   = valid;
        fill        = 1'b0;
        case (state)
            IDLE: begin
                if (!downloading && any_miss) begin
                    grant_nxt   = win;
                    addr_nxt    = slot_addr[win*AW +: AW];
                    req_nxt     = 1'b1;
                    refresh_nxt = 1'b0;
                    state_nxt   = WAIT_ACK;
                end else begin
                    refresh_nxt = 1'b1;
                end
            end
            WAIT_ACK: begin
                if (sdram_ack) begin
                    req_nxt = 1'b0;
                    // A controller may return data in the same cycle it acknowledges.
                    if (data_rdy) begin
                        fill      = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = WAIT_RDY;
                    end
                end
            end
            WAIT_RDY: begin
                if (data_rdy) begin
                    fill      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (fill && !downloading) valid_nxt[grant] = 1'b1;
        // A download rewrites SDRAM contents, so every cached word becomes stale.
        if (downloading) valid_nxt = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            valid      <= '0;
            grant      <= '0;
            sdram_req  <= 1'b0;
            sdram_addr <= '0;
            refresh_en <= 1'b1;
            for (int i = 0; i < SLOTS; i++) begin
                cache_addr[i] <= '0;
                cache_data[i] <= '0;
            end
        end else begin
            state      <= state_nxt;
            valid      <= valid_nxt;
            grant      <= grant_nxt;
            sdram_req  <= req_nxt;
            sdram_addr <= addr_nxt;
            refresh_en <= refresh_nxt;
            if (fill) begin
                cache_data[grant] <= data_read;
                cache_addr[grant] <= sdram_addr;
            end
        end
    end

endmodule

// File: tb/tb_jtframe_rom_arb.sv
// Bench for jtframe_rom_arb: SDRAM responder with address scoreboard, directed scenarios and a random cache-model phase.
module tb_jtframe_rom_arb;

    localparam int SLOTS = 4;
    localparam int AW    = 22;
    localparam int DW    = 32;

    logic                clk = 1'b0;
    logic                rst;
    logic                downloading;
    logic [SLOTS-1:0]    slot_req;
    logic [SLOTS*AW-1:0] slot_addr;
    logic [SLOTS-1:0]    slot_ok;
    logic [SLOTS*DW-1:0] slot_dout;
    logic                sdram_req;
    logic [AW-1:0]       sdram_addr;
    logic                sdram_ack;
    logic                data_rdy;
    logic [DW-1:0]       data_read;
    logic                refresh_en;

    jtframe_rom_arb #(.SLOTS(SLOTS), .AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .downloading(downloading),
        .slot_req   (slot_req),
        .slot_addr  (slot_addr),
        .slot_ok    (slot_ok),
        .slot_dout  (slot_dout),
        .sdram_req  (sdram_req),
        .sdram_addr (sdram_addr),
        .sdram_ack  (sdram_ack),
        .data_rdy   (data_rdy),
        .data_read  (data_read),
        .refresh_en (refresh_en)
    );

    // Handshake: the arbiter holds sdram_req/sdram_addr until a one-cycle sdram_ack; data_rdy is a one-cycle data strobe.

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- scoreboard state ----------------
    logic [AW-1:0] exp_q[$];
    logic [AW-1:0] gnt_log[$];
    int n_pass  = 0;
    int n_total = 0;
    int n_req   = 0;
    int done    = 0;
    int phase   = 0;
    int last_rdy_cyc = -100;
    int last_gap     = 0;
    bit resp_en = 1'b1;
    bit sb_on   = 1'b1;
    int ack_dly = 3;
    int rdy_dly = 4;
    logic [SLOTS-1:0] ok_before, ok_after;
    bit            m_valid [SLOTS];
    logic [AW-1:0] m_addr  [SLOTS];

    function automatic logic [DW-1:0] mdata(input logic [AW-1:0] a);
        if (a == 22'h000100) return 32'hDEADBEEF;
        return {a[15:0] ^ 16'h5A3C, a[15:0]};
    endfunction

    function automatic logic [DW-1:0] dout_of(input int s);
        return slot_dout[s*DW +: DW];
    endfunction

    // ---------------- driver tasks ----------------
    task automatic set_addr(input int s, input logic [AW-1:0] a);
        slot_addr[s*AW +: AW] = a;
    endtask

    task automatic wait_done(input int target, input int budget, input string name);
        int c = 0;
        while (done < target && c < budget) begin
            @(posedge clk);
            c++;
        end
        n_total++;
        if (done < target) $display("FAIL %s: timeout, transactions %0d expected %0d", name, done, target);
        else n_pass++;
    endtask

    task automatic wait_req(input int target, input int budget, input string name);
        int c = 0;
        while (n_req < target && c < budget) begin
            @(posedge clk);
            c++;
        end
        n_total++;
        if (n_req < target) $display("FAIL %s: timeout, requests %0d expected %0d", name, n_req, target);
        else n_pass++;
    endtask

    // ---------------- SDRAM controller model ----------------
    task automatic serve();
        logic [AW-1:0] a;
        logic [AW-1:0] e;
        bit hold;
        a = sdram_addr;
        n_req++;
        phase = 0;
        gnt_log.push_back(a);
        last_gap = cyc - last_rdy_cyc;
        if (sb_on) begin
            n_total++;
            if (exp_q.size() == 0) begin
                $display("FAIL sb_unexpected_req: got addr %h expected no request", a);
            end else begin
                e = exp_q.pop_front();
                if (a !== e) $display("FAIL sb_addr: got %h expected %h", a, e);
                else n_pass++;
            end
        end
        hold = 1'b1;
        repeat (ack_dly - 1) begin
            @(negedge clk);
            if (sdram_req !== 1'b1 || sdram_addr !== a) hold = 1'b0;
        end
        sdram_ack = 1'b1;
        if (rdy_dly == 0) begin
            data_rdy     = 1'b1;
            data_read    = mdata(a);
            ok_before    = slot_ok;
            last_rdy_cyc = cyc;
        end
        @(negedge clk);
        sdram_ack = 1'b0;
        if (ack_dly > 1) begin
            n_total++;
            if (hold !== 1'b1) $display("FAIL req_hold: req/addr stable %0d expected 1", hold);
            else n_pass++;
        end
        n_total++;
        if (sdram_req !== 1'b0) $display("FAIL req_drop_after_ack: got %b expected 0", sdram_req);
        else n_pass++;
        if (rdy_dly == 0) begin
            ok_after = slot_ok;
            data_rdy = 1'b0;
        end else begin
            phase = 1;
            repeat (rdy_dly - 1) @(negedge clk);
            data_rdy     = 1'b1;
            data_read    = mdata(a);
            ok_before    = slot_ok;
            last_rdy_cyc = cyc;
            @(negedge clk);
            ok_after = slot_ok;
            data_rdy = 1'b0;
        end
        done++;
    endtask

    initial begin
        sdram_ack = 1'b0;
        data_rdy  = 1'b0;
        data_read = '0;
        forever begin
            @(negedge clk);
            if (resp_en && sdram_req === 1'b1 && !rst) serve();
        end
    end

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        slot_req = '1;
        slot_addr = '0;
        repeat (3) @(negedge clk);
        n_total++; if (sdram_req !== 1'b0) $display("FAIL rst_req: got %b expected 0", sdram_req); else n_pass++;
        n_total++; if (sdram_addr !== '0) $display("FAIL rst_addr: got %h expected 0", sdram_addr); else n_pass++;
        n_total++; if (refresh_en !== 1'b1) $display("FAIL rst_refresh: got %b expected 1", refresh_en); else n_pass++;
        n_total++; if (slot_ok !== '0) $display("FAIL rst_slot_ok: got %b expected 0", slot_ok); else n_pass++;
        n_total++; if (slot_dout !== '0) $display("FAIL rst_dout: got %h expected 0", slot_dout); else n_pass++;
        slot_req = '0;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_miss_fill();
        int base = done;
        set_addr(1, 22'h000100);
        exp_q.push_back(22'h000100);
        slot_req[1] = 1'b1;
        wait_done(base + 1, 60, "t1_done");
        @(negedge clk);
        n_total++; if (ok_before[1] !== 1'b0) $display("FAIL t1_ok_early: got %b expected 0", ok_before[1]); else n_pass++;
        n_total++; if (ok_after[1] !== 1'b1) $display("FAIL t1_ok_after_rdy: got %b expected 1", ok_after[1]); else n_pass++;
        n_total++; if (dout_of(1) !== 32'hDEADBEEF) $display("FAIL t1_dout: got %h expected DEADBEEF", dout_of(1)); else n_pass++;
        n_total++; if (refresh_en !== 1'b1) $display("FAIL t1_refresh_idle: got %b expected 1", refresh_en); else n_pass++;
    endtask

    task automatic test_hit();
        int n0 = n_req;
        bit seen = 1'b0;
        slot_req[1] = 1'b0;
        @(negedge clk);
        slot_req[1] = 1'b1;
        #1;
        n_total++; if (slot_ok[1] !== 1'b1) $display("FAIL t2_hit_same_cycle: got %b expected 1", slot_ok[1]); else n_pass++;
        repeat (6) begin
            @(negedge clk);
            if (sdram_req !== 1'b0) seen = 1'b1;
        end
        n_total++; if (seen !== 1'b0 || n_req != n0) $display("FAIL t2_no_req: pulse %b reqs %0d expected 0 and %0d", seen, n_req, n0); else n_pass++;
        slot_req[1] = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_priority();
        int base = done;
        set_addr(0, 22'h000200);
        set_addr(2, 22'h000300);
`ifdef JTFRAME_ARB_RR_EN
        exp_q.push_back(22'h000300);
        exp_q.push_back(22'h000200);
`else
        exp_q.push_back(22'h000200);
        exp_q.push_back(22'h000300);
`endif
        slot_req = 4'b0101;
        wait_done(base + 2, 120, "t3_done");
        @(negedge clk);
        n_total++; if (slot_ok !== 4'b0101) $display("FAIL t3_ok: got %b expected 0101", slot_ok); else n_pass++;
        n_total++; if (dout_of(2) !== mdata(22'h000300)) $display("FAIL t3_dout2: got %h expected %h", dout_of(2), mdata(22'h000300)); else n_pass++;
        slot_req = '0;
        @(negedge clk);
    endtask

    task automatic test_starvation();
`ifdef JTFRAME_ARB_RR_EN
        int t4_reqs = 5;
`else
        int t4_reqs = 6;
`endif
        int rbase = n_req;
        int dbase = done;
        int pos = -1;
        sb_on = 1'b0;
        gnt_log.delete();
        set_addr(0, 22'h000500);
        set_addr(3, 22'h000400);
        slot_req = 4'b1001;
        for (int k = 1; k <= 5; k++) begin
            wait_req(rbase + k, 60, "t4_req");
            @(negedge clk);
            if (k < 5) set_addr(0, 22'h000500 + 22'(k));
            else slot_req[0] = 1'b0;
        end
        wait_done(dbase + t4_reqs, 100, "t4_done");
        @(negedge clk);
        for (int i = 0; i < gnt_log.size(); i++) if (gnt_log[i] == 22'h000400 && pos < 0) pos = i;
        n_total++; if (gnt_log.size() != t4_reqs) $display("FAIL t4_grants: got %0d expected %0d", gnt_log.size(), t4_reqs); else n_pass++;
`ifdef JTFRAME_ARB_RR_EN
        n_total++; if (pos < 0 || pos >= SLOTS) $display("FAIL t4_rr_slot3_pos: got %0d expected below %0d", pos, SLOTS); else n_pass++;
`else
        n_total++; if (pos != 5) $display("FAIL t4_starve_slot3_pos: got %0d expected 5", pos); else n_pass++;
`endif
        n_total++; if (slot_ok[3] !== 1'b1) $display("FAIL t4_ok3: got %b expected 1", slot_ok[3]); else n_pass++;
        n_total++; if (dout_of(3) !== mdata(22'h000400)) $display("FAIL t4_dout3: got %h expected %h", dout_of(3), mdata(22'h000400)); else n_pass++;
        slot_req[0] = 1'b1;
        #1;
        n_total++; if (slot_ok[0] !== 1'b1) $display("FAIL t4_drop_fill: got %b expected 1", slot_ok[0]); else n_pass++;
        #1;
        slot_req = '0;
        sb_on = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_download();
        int base = done;
        int nbase = n_req;
        int c = 0;
        bit bad_req = 1'b0, bad_ref = 1'b0, bad_ok = 1'b0;
        ack_dly = 3;
        rdy_dly = 4;
        set_addr(2, 22'h000600);
        exp_q.push_back(22'h000600);
        slot_req = 4'b0100;
        while (!(n_req > nbase && phase == 1) && c < 40) begin
            @(posedge clk);
            c++;
        end
        n_total++; if (phase != 1) $display("FAIL t5_reach_wait_rdy: phase %0d expected 1", phase); else n_pass++;
        @(negedge clk);
        downloading = 1'b1;
        @(negedge clk);
        set_addr(1, 22'h000100);
        slot_req[1] = 1'b1;
        #1;
        n_total++; if (slot_ok[1] !== 1'b0) $display("FAIL t5_valid_cleared: got %b expected 0", slot_ok[1]); else n_pass++;
        #1;
        slot_req[1] = 1'b0;
        wait_done(base + 1, 60, "t5_done");
        @(negedge clk);
        n_total++; if (ok_after[2] !== 1'b0) $display("FAIL t5_rdy_absorbed: got %b expected 0", ok_after[2]); else n_pass++;
        repeat (8) begin
            @(negedge clk);
            if (sdram_req !== 1'b0) bad_req = 1'b1;
            if (refresh_en !== 1'b1) bad_ref = 1'b1;
            if (slot_ok !== '0) bad_ok = 1'b1;
        end
        n_total++; if (bad_req) $display("FAIL t5_no_req: got 1 expected 0"); else n_pass++;
        n_total++; if (bad_ref) $display("FAIL t5_refresh: got 0 expected 1"); else n_pass++;
        n_total++; if (bad_ok) $display("FAIL t5_slot_ok: got nonzero expected 0"); else n_pass++;
        exp_q.push_back(22'h000600);
        downloading = 1'b0;
        wait_done(base + 2, 60, "t5_refetch");
        @(negedge clk);
        n_total++; if (slot_ok[2] !== 1'b1) $display("FAIL t5_ok_after_dl: got %b expected 1", slot_ok[2]); else n_pass++;
        slot_req = '0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int c = 0;
        resp_en = 1'b0;
        set_addr(3, 22'h000700);
        slot_req = 4'b1000;
        while (sdram_req !== 1'b1 && c < 10) begin
            @(negedge clk);
            c++;
        end
        n_total++; if (sdram_addr !== 22'h000700) $display("FAIL t6_addr: got %h expected 000700", sdram_addr); else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        n_total++; if (sdram_req !== 1'b0) $display("FAIL t6_req: got %b expected 0", sdram_req); else n_pass++;
        n_total++; if (refresh_en !== 1'b1) $display("FAIL t6_refresh: got %b expected 1", refresh_en); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        set_addr(0, 22'h000504);
        set_addr(1, 22'h000100);
        set_addr(2, 22'h000600);
        slot_req = 4'b0111;
        #1;
        n_total++; if (slot_ok !== '0) $display("FAIL t6_ok_after_rst: got %b expected 0", slot_ok); else n_pass++;
        #1;
        slot_req = '0;
        for (int i = 0; i < SLOTS; i++) m_valid[i] = 1'b0;
        resp_en = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int base = done;
        ack_dly = 1;
        rdy_dly = 0;
        set_addr(0, 22'h000800);
        set_addr(1, 22'h000900);
        exp_q.push_back(22'h000800);
        exp_q.push_back(22'h000900);
        slot_req = 4'b0011;
        wait_done(base + 2, 60, "t7_done");
        @(negedge clk);
        n_total++; if (last_gap != 2) $display("FAIL t7_gap: got %0d expected 2", last_gap); else n_pass++;
        n_total++; if (ok_after[1] !== 1'b1) $display("FAIL t7_same_cycle_fill: got %b expected 1", ok_after[1]); else n_pass++;
        n_total++; if (slot_ok[1:0] !== 2'b11) $display("FAIL t7_ok: got %b expected 11", slot_ok[1:0]); else n_pass++;
        n_total++; if (dout_of(0) !== mdata(22'h000800)) $display("FAIL t7_dout0: got %h expected %h", dout_of(0), mdata(22'h000800)); else n_pass++;
        m_valid[0] = 1'b1; m_addr[0] = 22'h000800;
        m_valid[1] = 1'b1; m_addr[1] = 22'h000900;
        slot_req = '0;
        @(negedge clk);
    endtask

    task automatic test_random();
        for (int n = 0; n < 12; n++) begin
            int s;
            logic [AW-1:0] a;
            bit hit;
            s = $urandom_range(0, SLOTS - 1);
            a = 22'h000A00 + 22'($urandom_range(0, 2));
            ack_dly = $urandom_range(1, 4);
            rdy_dly = $urandom_range(0, 3);
            hit = m_valid[s] && m_addr[s] == a;
            if (!hit) exp_q.push_back(a);
            set_addr(s, a);
            slot_req[s] = 1'b1;
            #1;
            n_total++; if (slot_ok[s] !== hit) $display("FAIL rnd_hit slot %0d addr %h: got %b expected %b", s, a, slot_ok[s], hit); else n_pass++;
            if (!hit) begin
                wait_done(done + 1, 80, "rnd_done");
                @(negedge clk);
                n_total++; if (slot_ok[s] !== 1'b1) $display("FAIL rnd_ok slot %0d: got %b expected 1", s, slot_ok[s]); else n_pass++;
                m_valid[s] = 1'b1;
                m_addr[s]  = a;
            end
            n_total++; if (dout_of(s) !== mdata(a)) $display("FAIL rnd_dout slot %0d: got %h expected %h", s, dout_of(s), mdata(a)); else n_pass++;
            slot_req[s] = 1'b0;
            @(negedge clk);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst = 1'b1;
        downloading = 1'b0;
        slot_req = '0;
        slot_addr = '0;
        test_reset();
        test_miss_fill();
        test_hit();
        test_priority();
        test_starvation();
        test_download();
        test_reset_mid();
        test_back_to_back();
        test_random();
        repeat (4) @(negedge clk);
        n_total++; if (exp_q.size() != 0) $display("FAIL sb_leftover: got %0d pending expected 0", exp_q.size()); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
